id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID->EXE pipeline register, directly downstream of the register file.
//  - Captures reg1/reg2 read data plus decoded control for one instruction per cycle.
//  - Supports stall (hold), flush (bubble) and bubble injection.
//  - Optionally re-reads write-back results so operands never go stale.
// PARAMETERS
//  DW      32  datapath width: PC and operand values
//  RW      4   register index width: 16 architectural registers
// PORTS
//  clk            in   1   pipeline clock, all state on posedge
//  rst            in   1   asynchronous, active-low reset
//  stall          in   1   hold all stage contents this cycle
//  flush          in   1   replace stage contents with a bubble (branch taken)
//  id_valid       in   1   ID stage holds a real instruction
//  id_pc          in   DW  PC+4 of the ID instruction
//  id_src1        in   RW  Rn index, as presented to the register file
//  id_src2        in   RW  Rm index, as presented to the register file
//  id_reg1        in   DW  Rn value from the register file
//  id_reg2        in   DW  Rm value from the register file
//  id_dest        in   RW  Rd index
//  id_exe_cmd     in   4   ALU command
//  id_mem_r       in   1   load
//  id_mem_w       in   1   store
//  id_wb_en       in   1   register write-back enable
//  id_b           in   1   branch
//  id_s           in   1   update status flags
//  id_imm         in   1   operand2 is immediate
//  id_shift_op    in   12  shifter operand field
//  id_simm24      in   24  signed branch offset
//  id_sr          in   4   NZCV at decode time
//  wb_en          in   1   write-back stage writes this cycle (bypass only)
//  wb_dest        in   RW  write-back destination (bypass only)
//  wb_value       in   DW  write-back data (bypass only)
//  ex_*           out  -   registered copy of every id_* input except id_valid; same widths
//  ex_valid       out  1   EXE holds a real instruction
// BEHAVIOUR
//  - Reset (rst=0, async): every ex_* output and ex_valid = 0; held until rst=1.
//  - Latency: 1 cycle. Inputs sampled at posedge appear on ex_* after that edge.
//  - Priority at each posedge: flush > stall > load.
//  - flush=1: ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s = 0.
//    - All other ex_* = 0.
//    - Applies even when stall=1 on the same edge.
//  - stall=1, flush=0: all ex_* hold, except operand refresh when WB_BYPASS_EN is defined.
//  - Load (stall=0, flush=0):
//    - id_valid=1: all fields captured, ex_valid = 1.
//    - id_valid=0: bubble loaded, identical to the flush result.
//  - Bubble invariant: ex_valid=0 => ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s are all 0.
//  - No combinational path from any input to any output.
//  - Reset asserted mid-stall or mid-flush: outputs clear immediately; no state survives.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - On load: if wb_en and wb_dest==id_src1, ex_reg1 <= wb_value instead of id_reg1.
//      Same rule for id_src2 -> ex_reg2. Both may match at once; both take wb_value.
//    - On stall, ex_valid=1: if wb_en and wb_dest==ex_src1, ex_reg1 <= wb_value.
//      Same rule for ex_src2 -> ex_reg2. Other fields hold.
//    - Flush still wins over both rules.
//  WB_BYPASS_EN undefined:
//    - wb_en, wb_dest, wb_value are ignored; ex_reg1/ex_reg2 are always id_reg1/id_reg2.
// TESTING
//  1 rst=0 with all id_* = 1s, then rst=1 -> all ex_* = 0 and ex_valid=0 before the first posedge.
//  2 Load id_pc=0x8, id_dest=3, id_exe_cmd=4'b0010, id_wb_en=1, id_valid=1
//    -> next cycle ex_pc=0x8, ex_dest=3, ex_exe_cmd=4'b0010, ex_wb_en=1, ex_valid=1.
//  3 Captured instruction, then stall=1 for 3 cycles while id_* change
//    -> ex_* unchanged for 3 cycles; new instruction appears 1 cycle after stall drops.
//  4 stall=1 and flush=1 on the same edge with ex_valid=1
//    -> ex_valid=0, ex_wb_en=0, ex_mem_w=0, all other ex_*=0.
//  5 Load id_src1=5, id_reg1=0x11, with wb_en=1, wb_dest=5, wb_value=0x99
//    -> with WB_BYPASS_EN: ex_reg1=0x99; without it: ex_reg1=0x11.
//  6 WB_BYPASS_EN: stall with ex_src2=7, then wb_en=1, wb_dest=7, wb_value=0xABCD
//    -> ex_reg2=0xABCD and ex_reg1 unchanged.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID->EXE pipeline register with stall (hold), flush/bubble, and async active-low reset.
// Optional macro WB_BYPASS_EN: refresh operands from the write-back bus on load and while stalled.
module id_ex_stage_reg #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [RW-1:0] id_src1,
  input  logic [RW-1:0] id_src2,
  input  logic [DW-1:0] id_reg1,
  input  logic [DW-1:0] id_reg2,
  input  logic [RW-1:0] id_dest,
  input  logic [3:0]    id_exe_cmd,
  input  logic          id_mem_r,
  input  logic          id_mem_w,
  input  logic          id_wb_en,
  input  logic          id_b,
  input  logic          id_s,
  input  logic          id_imm,
  input  logic [11:0]   id_shift_op,
  input  logic [23:0]   id_simm24,
  input  logic [3:0]    id_sr,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic [DW-1:0] ex_pc,
  output logic [RW-1:0] ex_src1,
  output logic [RW-1:0] ex_src2,
  output logic [DW-1:0] ex_reg1,
  output logic [DW-1:0] ex_reg2,
  output logic [RW-1:0] ex_dest,
  output logic [3:0]    ex_exe_cmd,
  output logic          ex_mem_r,
  output logic          ex_mem_w,
  output logic          ex_wb_en,
  output logic          ex_b,
  output logic          ex_s,
  output logic          ex_imm,
  output logic [11:0]   ex_shift_op,
  output logic [23:0]   ex_simm24,
  output logic [3:0]    ex_sr,
  output logic          ex_valid
);

  logic [DW-1:0] load_reg1, load_reg2;
  logic [DW-1:0] hold_reg1, hold_reg2;
  logic          bubble;

`ifdef WB_BYPASS_EN
  // Operand refresh: a stalled bubble has no live operands, so it never refreshes.
  always_comb begin
    load_reg1 = (wb_en && (wb_dest == id_src1)) ? wb_value : id_reg1;
    load_reg2 = (wb_en && (wb_dest == id_src2)) ? wb_value : id_reg2;
    hold_reg1 = (ex_valid && wb_en && (wb_dest == ex_src1)) ? wb_value : ex_reg1;
    hold_reg2 = (ex_valid && wb_en && (wb_dest == ex_src2)) ? wb_value : ex_reg2;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_dest, wb_value};

  always_comb begin
    load_reg1 = id_reg1;
    load_reg2 = id_reg2;
    hold_reg1 = ex_reg1;
    hold_reg2 = ex_reg2;
  end
`endif

  // A flush wins over stall; an unstalled load of an invalid instruction is also a bubble.
  assign bubble = flush || (!stall && !id_valid);

  // ID -> EXE stage boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_reg1     <= '0;
      ex_reg2     <= '0;
      ex_dest     <= '0;
      ex_exe_cmd  <= '0;
      ex_mem_r    <= 1'b0;
      ex_mem_w    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_imm      <= 1'b0;
      ex_shift_op <= '0;
      ex_simm24   <= '0;
      ex_sr       <= '0;
    end else if (stall) begin
      ex_reg1 <= hold_reg1;
      ex_reg2 <= hold_reg2;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_src1     <= id_src1;
      ex_src2     <= id_src2;
      ex_reg1     <= load_reg1;
      ex_reg2     <= load_reg2;
      ex_dest     <= id_dest;
      ex_exe_cmd  <= id_exe_cmd;
      ex_mem_r    <= id_mem_r;
      ex_mem_w    <= id_mem_w;
      ex_wb_en    <= id_wb_en;
      ex_b        <= id_b;
      ex_s        <= id_s;
      ex_imm      <= id_imm;
      ex_shift_op <= id_shift_op;
      ex_simm24   <= id_simm24;
      ex_sr       <= id_sr;
    end
  end

endmodule
